// File: rtl/bnn_load_ctrl.sv
// Nibble-serial loader for NUM_NEURONS weight/threshold slots: W_LO, W_HI, THR nibbles then a one-cycle write.
// Define BNN_LOAD_PARITY_EN to add a fourth XOR check nibble per neuron (CHK state).
module bnn_load_ctrl #(
  parameter int NUM_NEURONS = 8,
  parameter int TIMEOUT     = 255,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          nib_valid,
  input  logic [3:0]    nib_data,
  output logic          nib_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_weight,
  output logic [3:0]    wr_thresh,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          infer_en
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);
  localparam logic [TW-1:0] IDLE_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_LO,
    W_HI,
    THR,
`ifdef BNN_LOAD_PARITY_EN
    CHK,
`endif
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] idx;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    w_asm;
  logic [3:0]    thr_src;
  logic          xfer, starved, start_acc, ld_out;

`ifdef BNN_LOAD_PARITY_EN
  logic [3:0] th_asm;
  logic       chk_ok;
  assign chk_ok  = (nib_data == (w_asm[3:0] ^ w_asm[7:4] ^ th_asm));
  assign thr_src = th_asm;
`else
  assign thr_src = nib_data;
`endif

  assign xfer    = nib_valid & nib_ready;
  // the counter is about to reach TIMEOUT on this idle cycle
  assign starved = ~nib_valid & (idle_cnt == IDLE_LIM);

  assign wr_en    = (state == WRITE);
  assign wr_addr  = idx;
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign infer_en = (state == DONE);

  always_comb begin
    state_d   = state;
    nib_ready = 1'b0;
    busy      = 1'b0;
    start_acc = 1'b0;
    ld_out    = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = W_LO;
          start_acc = 1'b1;
        end
      end
      W_LO: begin
        nib_ready = 1'b1;
        busy      = 1'b1;
        if (nib_valid)    state_d = W_HI;
        else if (starved) state_d = ERR;
      end
      W_HI: begin
        nib_ready = 1'b1;
        busy      = 1'b1;
        if (nib_valid)    state_d = THR;
        else if (starved) state_d = ERR;
      end
      THR: begin
        nib_ready = 1'b1;
        busy      = 1'b1;
`ifdef BNN_LOAD_PARITY_EN
        if (nib_valid)    state_d = CHK;
        else if (starved) state_d = ERR;
`else
        if (nib_valid) begin
          state_d = WRITE;
          ld_out  = 1'b1;
        end else if (starved) begin
          state_d = ERR;
        end
`endif
      end
`ifdef BNN_LOAD_PARITY_EN
      CHK: begin
        nib_ready = 1'b1;
        busy      = 1'b1;
        if (nib_valid) begin
          state_d = chk_ok ? WRITE : ERR;
          ld_out  = chk_ok;
        end else if (starved) begin
          state_d = ERR;
        end
      end
`endif
      WRITE: begin
        busy    = 1'b1;
        state_d = (idx == LAST_IDX) ? DONE : W_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      idle_cnt  <= '0;
      w_asm     <= '0;
      wr_weight <= '0;
      wr_thresh <= '0;
`ifdef BNN_LOAD_PARITY_EN
      th_asm    <= '0;
`endif
    end else begin
      state <= state_d;
      if (start_acc)
        idx <= '0;
      else if (state == WRITE && idx != LAST_IDX)
        idx <= idx + AW'(1);
      if (start_acc || xfer || !nib_ready)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + TW'(1);
      if (xfer && state == W_LO) w_asm[3:0] <= nib_data;
      if (xfer && state == W_HI) w_asm[7:4] <= nib_data;
`ifdef BNN_LOAD_PARITY_EN
      if (xfer && state == THR) th_asm <= nib_data;
`endif
      // output registers only change when a complete neuron is committed
      if (ld_out) begin
        wr_weight <= w_asm;
        wr_thresh <= thr_src;
      end
    end
  end

endmodule

// File: tb/tb_bnn_load_ctrl.sv
// Randomized bench for bnn_load_ctrl against a nibble-list reference model; honours BNN_LOAD_PARITY_EN.
module tb_bnn_load_ctrl;

  localparam int N  = 8;
  localparam int TO = 255;
`ifdef BNN_LOAD_PARITY_EN
  localparam int NPN = 4;
`else
  localparam int NPN = 3;
`endif
  localparam int TOTAL = N * NPN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       nib_valid = 1'b0;
  logic [3:0] nib_data = 4'h0;
  logic       nib_ready, wr_en, busy, done, err, infer_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_weight;
  logic [3:0] wr_thresh;

  int n_chk = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int base;
  logic [3:0] nibs [TOTAL];

  bnn_load_ctrl #(.NUM_NEURONS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nib_valid(nib_valid), .nib_data(nib_data),
    .nib_ready(nib_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_weight(wr_weight),
    .wr_thresh(wr_thresh), .busy(busy), .done(done), .err(err), .infer_en(infer_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill(input bit fixed_first);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 3; j++) nibs[k*NPN+j] = 4'($urandom);
`ifdef BNN_LOAD_PARITY_EN
      nibs[k*NPN+3] = nibs[k*NPN] ^ nibs[k*NPN+1] ^ nibs[k*NPN+2];
`endif
    end
    if (fixed_first) begin
      nibs[0] = 4'h0; nibs[1] = 4'hF; nibs[2] = 4'h5;
`ifdef BNN_LOAD_PARITY_EN
      nibs[3] = 4'hA;
`endif
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push(input logic [3:0] d);
    int t = 0;
    @(negedge clk);
    nib_valid = 1'b1; nib_data = d;
    while (!nib_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check("push_wait", 0, 1);
    @(posedge clk); #1;
    nib_valid = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid toggles, 2: random valid; spam drives random start
  task automatic run_load(input int mode, input bit spam);
    int ptr = 0, wcnt = 0, cyc = 0;
    bit pend = 1'b0, xf;
    pulse_start();
    while (cyc < 2000) begin
      check("wr_en", wr_en, pend);
      if (pend) begin
        check("wr_addr", wr_addr, wcnt);
        check("wr_weight", wr_weight, {nibs[wcnt*NPN+1], nibs[wcnt*NPN]});
        check("wr_thresh", wr_thresh, nibs[wcnt*NPN+2]);
        wcnt++;
      end else if (wcnt > 0) begin
        check("hold_weight", wr_weight, {nibs[(wcnt-1)*NPN+1], nibs[(wcnt-1)*NPN]});
      end
      if (wcnt == N) break;
      check("ready", nib_ready, !pend);
      check("busy", busy, 1);
      nib_valid = (ptr < TOTAL) && (mode == 0 || (mode == 1 && cyc[0] == 1'b0) ||
                                    (mode == 2 && $urandom_range(0, 1) == 1));
      nib_data  = (ptr < TOTAL) ? nibs[ptr] : 4'h0;
      start     = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      xf   = nib_valid && nib_ready;
      pend = xf && ((ptr + 1) % NPN == 0);
      if (xf) ptr++;
      @(negedge clk);
      cyc++;
    end
    if (wcnt != N) check("load_complete", wcnt, N);
    nib_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    check("done", done, 1);
    check("infer_en", infer_en, 1);
    check("busy_end", busy, 0);
    check("err_end", err, 0);
    check("ready_end", nib_ready, 0);
    check("wr_en_end", wr_en, 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", nib_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_weight", wr_weight, 0);
    check("rst_thresh", wr_thresh, 0);
    check("rst_flags", {busy, done, err, infer_en}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_infer_en", infer_en, 0);
    check("idle_ready", nib_ready, 0);

    fill(1'b1); run_load(0, 1'b0);
    fill(1'b1); run_load(1, 1'b0);
    fill(1'b0); run_load(2, 1'b1);

    // timeout: one full neuron plus one nibble, then starve the loader
    fill(1'b0);
    pulse_start();
    base = wr_cnt;
    for (int i = 0; i < NPN + 1; i++) push(nibs[i]);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("to_err_early", err, 0);
    check("to_busy_early", busy, 1);
    @(posedge clk); #1;
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_infer_en", infer_en, 0);
    check("to_writes", wr_cnt - base, 1);
    check("to_last_weight", wr_weight, {nibs[1], nibs[0]});
    pulse_start();
    check("to_err_cleared", err, 0);
    check("to_restart_busy", busy, 1);

    // asynchronous reset in W_HI of neuron 2
    base = wr_cnt;
    for (int i = 0; i < 2 * NPN + 1; i++) push(nibs[i]);
    check("mid_writes", wr_cnt - base, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", nib_ready, 0);
    check("arst_addr", wr_addr, 0);
    check("arst_data", {wr_weight, wr_thresh}, 0);
    check("arst_flags", {wr_en, busy, done, err, infer_en}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nib_valid = 1'b1; nib_data = 4'($urandom);
    end
    @(negedge clk);
    nib_valid = 1'b0;
    check("post_rst_writes", wr_cnt - base, 0);
    check("post_rst_ready", nib_ready, 0);
    check("post_rst_busy", busy, 0);

    fill(1'b0); run_load(0, 1'b0);

`ifdef BNN_LOAD_PARITY_EN
    base = wr_cnt;
    pulse_start();
    push(4'h0); push(4'hF); push(4'h5); push(4'hB);
    check("par_err", err, 1);
    check("par_busy", busy, 0);
    @(negedge clk);
    check("par_writes", wr_cnt - base, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bnn_load_ctrl.md
BNN_LOAD_CTRL -- requirements
Module: bnn_load_ctrl

Interface
REQ-001 Parameter NUM_NEURONS, default 8, number of neurons sequenced; address width AW = clog2(NUM_NEURONS).
REQ-002 Parameter TIMEOUT, default 255, max idle cycles between accepted nibbles during load.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a full reload of all neurons.
REQ-006 nib_valid  input  1  nibble source has data.
REQ-007 nib_data  input  4  nibble payload.
REQ-008 nib_ready  output  1  controller can accept a nibble.
REQ-009 wr_en  output  1  one-cycle write strobe to neuron parameter store.
REQ-010 wr_addr  output  AW  neuron index being written.
REQ-011 wr_weight  output  8  assembled weight byte.
REQ-012 wr_thresh  output  4  threshold nibble.
REQ-013 busy  output  1  load sequence in progress.
REQ-014 done  output  1  last load completed successfully.
REQ-015 err  output  1  last load aborted.
REQ-016 infer_en  output  1  datapath outputs valid; parameters stable.

Function
REQ-017 States: IDLE, W_LO, W_HI, THR, (CHK when parity enabled), WRITE, DONE, ERR.
REQ-018 Nibble transfer occurs only on a cycle with nib_valid=1 and nib_ready=1.
REQ-019 nib_ready = 1 only in W_LO, W_HI, THR, CHK; 0 otherwise.
REQ-020 IDLE/DONE/ERR with start=1 -> W_LO next cycle; neuron index = 0; done=0, err=0, timeout counter = 0.
REQ-021 start ignored while busy.
REQ-022 W_LO transfer -> weight[3:0] = nib_data, go W_HI; W_HI transfer -> weight[7:4], go THR; THR transfer -> thresh = nib_data, go WRITE (or CHK when parity enabled).
REQ-023 WRITE lasts exactly one cycle: wr_en=1, wr_addr = neuron index, wr_weight/wr_thresh = assembled values; wr_en=0 in every other state.
REQ-024 After WRITE: index < NUM_NEURONS-1 -> index+1, go W_LO; index = NUM_NEURONS-1 -> go DONE (no wrap of index).
REQ-025 Latency: third (last) nibble of a neuron accepted at cycle N -> wr_en at cycle N+1 (parity disabled).
REQ-026 Timeout counter: in nibble states, cleared on each transfer, incremented otherwise; reaching TIMEOUT -> ERR, no write of the partial neuron.
REQ-027 busy = 1 in W_LO, W_HI, THR, CHK, WRITE; 0 otherwise.
REQ-028 done = 1 in DONE, err = 1 in ERR; both held until next accepted start.
REQ-029 infer_en = 1 only in DONE; 0 in all other states including IDLE after reset.
REQ-030 Neurons written before an error keep their new values; no rollback.
REQ-031 wr_weight/wr_thresh hold last assembled values when wr_en=0.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE, index=0, weight/thresh regs=0, timeout counter=0.
REQ-033 During reset: nib_ready=0, wr_en=0, wr_addr=0, wr_weight=0, wr_thresh=0, busy=0, done=0, err=0, infer_en=0.
REQ-034 Reset mid-load abandons the sequence; no wr_en pulse is generated on or after reset release until a new start.

Configuration
REQ-035 Macro BNN_LOAD_PARITY_EN: when defined, each neuron carries a 4th nibble in CHK state; it shall equal XOR of the weight-low, weight-high and threshold nibbles.
REQ-036 With BNN_LOAD_PARITY_EN: match -> WRITE; mismatch -> ERR without writing that neuron; last-nibble-to-wr_en latency = 1 cycle after the check nibble.
REQ-037 Without BNN_LOAD_PARITY_EN: CHK state absent, 3 nibbles per neuron, THR -> WRITE directly.

Verification
REQ-038 Reset, then start pulse, stream 24 nibbles with nib_valid=1 every cycle (parity off) -> 8 wr_en pulses, addr 0..7, neuron 0 weight 0xF0 thresh 0x5 from nibbles 0,F,5; then done=1, infer_en=1.
REQ-039 nib_valid toggled 1/0 each cycle during load -> identical write data and addresses, writes spaced by gaps; no extra transfers while nib_ready=0.
REQ-040 Stop after 4 nibbles, hold nib_valid=0 for 255 cycles -> err=1, busy=0, only neuron 0 written, infer_en=0; next start clears err.
REQ-041 start re-asserted mid-load at neuron 3 -> ignored, sequence finishes at addr 7.
REQ-042 rst_n low during W_HI of neuron 2 -> all outputs 0 immediately; after release no wr_en until start.
REQ-043 BNN_LOAD_PARITY_EN: nibbles 0,F,5,A -> write addr 0; nibbles 0,F,5,B -> err=1, no wr_en for addr 0.
